// File: rtl/demux1x2x32_buf_pkg.sv
// Shared widths and branch-select encodings
// for the buffered 1-to-2 result demux.
package demux1x2x32_buf_pkg;

  localparam int DATA_W = 32;

  localparam logic SEL_Y0 = 1'b0;
  localparam logic SEL_Y1 = 1'b1;

endpackage

// File: rtl/demux1x2x32_buf_fifo_sync.sv
// Small synchronous FIFO with masked head output.
// Storage is not cleared by reset.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign valid = ~empty;
  assign pop   = valid & pop_ready;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/demux1x2x32_buf.sv
// Buffered 1-to-2 demux: steers a0 into one of
// two per-branch FIFOs with valid/ready flow control.
module demux1x2x32_buf
  import demux1x2x32_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;

  // Readiness depends only on fullness, never on
  // the consumer's ready, so no look-ahead path.
  assign in_ready = ~rst & ((s == SEL_Y1) ? ~full1 : ~full0);
  assign push0 = in_valid & (s == SEL_Y0) & ~full0 & ~rst;
  assign push1 = in_valid & (s == SEL_Y1) & ~full1 & ~rst;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .din       (a0),
    .pop_ready (y0_ready),
    .dout      (y0),
    .valid     (y0_valid),
    .full      (full0),
    .empty     (empty0),
    .cnt       (cnt0)
  );

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .din       (a0),
    .pop_ready (y1_ready),
    .dout      (y1),
    .valid     (y1_valid),
    .full      (full1),
    .empty     (empty1),
    .cnt       (cnt1)
  );

  logic unused;
  assign unused = empty0 ^ empty1;

endmodule
